// File: rtl/lock_pkg.sv
// Shared state encoding and helpers for the keypad lock controller.
package lock_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StEntry   = 3'd1,
      StCheck   = 3'd2,
      StOpen    = 3'd3,
      StNewCode = 3'd4,
      StLockout = 3'd5
   } lock_state_e;

   localparam int unsigned TimerW  = 16;
   localparam logic [2:0]  FailSat = 3'd7;

   function automatic logic [2:0] sat_inc(logic [2:0] v);
      return (v == FailSat) ? v : v + 3'd1;
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; expired is high once the count has reached zero.
module lock_timer import lock_pkg::*; #(
   parameter int unsigned W = TimerW
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/lock_seq_ctrl.sv
// Keypad code lock: digit entry, code check, timed unlock, code change and
// lockout after repeated failures, all timed by a single shared timer.
module lock_seq_ctrl import lock_pkg::*; #(
   parameter int unsigned        NDIG      = 4,
   parameter logic [4*NDIG-1:0]  INIT_CODE = 16'h1234,
   parameter int unsigned        MAX_FAIL  = 3,
   parameter int unsigned        ENTRY_TO  = 500,
   parameter int unsigned        OPEN_CYC  = 1000,
   parameter int unsigned        LOCK_CYC  = 2000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       key_enter,
   input  logic       key_change,
   output logic       unlock,
   output logic       buzzer,
   output logic [2:0] fail_cnt,
   output logic [2:0] state
);

   localparam int unsigned        BufW     = 4 * NDIG;
   localparam int unsigned        CntW     = $clog2(NDIG + 1);
   localparam logic [CntW-1:0]    CntFull  = CntW'(NDIG);
   localparam logic [2:0]         FailMax  = 3'(MAX_FAIL);
   // Timer is loaded with N-1 so a state lasts exactly N cycles.
   localparam logic [TimerW-1:0]  EntryLd  = TimerW'(ENTRY_TO - 1);
   localparam logic [TimerW-1:0]  OpenLd   = TimerW'(OPEN_CYC - 1);
   localparam logic [TimerW-1:0]  LockLd   = TimerW'(LOCK_CYC - 1);

   lock_state_e         state_q, state_d;
   logic [BufW-1:0]     buf_q, buf_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [BufW-1:0]     code_q, code_d;
   logic [2:0]          fail_q, fail_d;
   logic [2:0]          fail_inc;
   logic                unlock_q, unlock_d;
   logic                buzzer_q, buzzer_d;
   logic                tmr_load, tmr_exp;
   logic [TimerW-1:0]   tmr_val;
   logic                match;

   assign match    = (cnt_q == CntFull) && (buf_q == code_q);
   assign fail_inc = sat_inc(fail_q);

   lock_timer #(
      .W (TimerW)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_exp)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      buf_d    = buf_q;
      cnt_d    = cnt_q;
      code_d   = code_q;
      fail_d   = fail_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      unique case (state_q)
         StIdle: begin
            if (key_valid && !key_enter) begin
               state_d  = StEntry;
               buf_d    = BufW'(key_digit);
               cnt_d    = CntW'(1);
               tmr_load = 1'b1;
               tmr_val  = EntryLd;
            end
         end
         StEntry, StNewCode: begin
            if (key_enter) begin
               if (state_q == StEntry) begin
                  state_d = StCheck;
               end else begin
                  if (cnt_q == CntFull) code_d = buf_q;
                  state_d = StIdle;
               end
            end else if (key_valid) begin
               tmr_load = 1'b1;
               tmr_val  = EntryLd;
               if (cnt_q < CntFull) begin
                  buf_d = (buf_q << 4) | BufW'(key_digit);
                  cnt_d = cnt_q + CntW'(1);
               end
            end else if (tmr_exp) begin
               state_d = StIdle;
            end
         end
         StCheck: begin
            buf_d = '0;
            cnt_d = '0;
            if (match) begin
               fail_d   = '0;
               state_d  = StOpen;
               tmr_load = 1'b1;
               tmr_val  = OpenLd;
            end else begin
               fail_d = fail_inc;
               if (fail_inc >= FailMax) begin
                  state_d  = StLockout;
                  tmr_load = 1'b1;
                  tmr_val  = LockLd;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StOpen: begin
            if (key_enter) begin
               state_d = StIdle;
            end else if (key_change) begin
               state_d  = StNewCode;
               tmr_load = 1'b1;
               tmr_val  = EntryLd;
            end else if (tmr_exp) begin
               state_d = StIdle;
            end
         end
         StLockout: begin
            if (tmr_exp) begin
               state_d = StIdle;
               fail_d  = '0;
            end
         end
         default: state_d = StIdle;
      endcase
      if (state_d == StIdle) begin
         buf_d = '0;
         cnt_d = '0;
      end
   end

   always_comb begin
      unlock_d = (state_d == StOpen);
      buzzer_d = (state_d == StLockout);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_q    <= '0;
         cnt_q    <= '0;
         code_q   <= INIT_CODE;
         fail_q   <= '0;
         unlock_q <= 1'b0;
         buzzer_q <= 1'b0;
      end else begin
         buf_q    <= buf_d;
         cnt_q    <= cnt_d;
         code_q   <= code_d;
         fail_q   <= fail_d;
         unlock_q <= unlock_d;
         buzzer_q <= buzzer_d;
      end
   end

   assign unlock   = unlock_q;
   assign buzzer   = buzzer_q;
   assign fail_cnt = fail_q;
   assign state    = state_q;

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Directed bench for lock_seq_ctrl with a queue of expected observations.
module tb_lock_seq_ctrl;
   import lock_pkg::*;

   logic       clk;
   logic       reset;
   logic       key_valid;
   logic [3:0] key_digit;
   logic       key_enter;
   logic       key_change;
   logic       unlock;
   logic       buzzer;
   logic [2:0] fail_cnt;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;
   int bcnt;
   int ucnt;

   typedef struct {
      string      tag;
      logic [7:0] v;
   } exp_t;

   exp_t exp_q[$];

   lock_seq_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .key_valid  (key_valid),
      .key_digit  (key_digit),
      .key_enter  (key_enter),
      .key_change (key_change),
      .unlock     (unlock),
      .buzzer     (buzzer),
      .fail_cnt   (fail_cnt),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [2:0] st, input logic u, input logic b,
                       input logic [2:0] fc);
      exp_t e;
      e.tag = tag;
      e.v   = {st, u, b, fc};
      exp_q.push_back(e);
   endtask

   task automatic pop_check();
      exp_t       e;
      logic [7:0] obs;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard: observed empty queue required an entry");
      end else begin
         e   = exp_q.pop_front();
         obs = {state, unlock, buzzer, fail_cnt};
         assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s: state/unlock/buzzer/fail_cnt observed %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d",
                   e.tag, obs[7:5], obs[4], obs[3], obs[2:0], e.v[7:5], e.v[4], e.v[3], e.v[2:0]);
         end
      end
   endtask

   task automatic check_now(input string tag, input logic [2:0] st, input logic u,
                            input logic b, input logic [2:0] fc);
      push(tag, st, u, b, fc);
      pop_check();
   endtask

   task automatic step(input string tag, input logic [2:0] st, input logic u,
                       input logic b, input logic [2:0] fc);
      push(tag, st, u, b, fc);
      tick(1);
      pop_check();
   endtask

   task automatic key(input logic [3:0] d);
      key_valid = 1'b1;
      key_digit = d;
      tick(1);
      key_valid = 1'b0;
   endtask

   task automatic code4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d);
      key(a);
      key(b);
      key(c);
      key(d);
   endtask

   // Commit with enter, then expect the CHECK outcome one edge later.
   task automatic commit(input string tag, input logic [2:0] st, input logic u,
                         input logic b, input logic [2:0] fc);
      key_enter = 1'b1;
      tick(1);
      key_enter = 1'b0;
      step(tag, st, u, b, fc);
   endtask

   initial begin
      key_valid  = 1'b0;
      key_digit  = 4'h0;
      key_enter  = 1'b0;
      key_change = 1'b0;
      reset      = 1'b1;
      #2 reset = 1'b0;
      #1 check_now("reset", StIdle, 1'b0, 1'b0, 3'd0);
      tick(2);
      reset = 1'b1;
      tick(1);
      check_now("idle_after_rst", StIdle, 1'b0, 1'b0, 3'd0);

      // Correct initial code
      key(4'h1);
      check_now("first_digit", StEntry, 1'b0, 1'b0, 3'd0);
      key(4'h2);
      key(4'h3);
      key(4'h4);
      key_enter = 1'b1;
      step("enter_check", StCheck, 1'b0, 1'b0, 3'd0);
      key_enter = 1'b0;
      step("unlock", StOpen, 1'b1, 1'b0, 3'd0);
      key_enter = 1'b1;
      step("open_exit", StIdle, 1'b0, 1'b0, 3'd0);
      key_enter = 1'b0;

      // Three wrong entries lead to lockout
      for (int i = 1; i <= 3; i++) begin
         code4(4'h5, 4'h5, 4'h5, 4'h5);
         commit($sformatf("wrong%0d", i), (i == 3) ? StLockout : StIdle, 1'b0, (i == 3),
                3'(i));
      end
      bcnt = buzzer ? 1 : 0;
      for (int i = 0; i < 2100 && buzzer; i++) begin
         key_valid  = (i == 10);
         key_digit  = 4'h1;
         key_enter  = (i == 11);
         key_change = (i == 12);
         tick(1);
         if (buzzer) bcnt++;
      end
      key_valid  = 1'b0;
      key_enter  = 1'b0;
      key_change = 1'b0;
      checks++;
      assert (bcnt == 2000) else begin
         errors++;
         $error("FAIL lock_len: buzzer cycles observed %0d required 2000", bcnt);
      end
      check_now("lock_done", StIdle, 1'b0, 1'b0, 3'd0);

      // Entry timeout keeps the failure count
      code4(4'h5, 4'h5, 4'h5, 4'h5);
      commit("pre_to_fail", StIdle, 1'b0, 1'b0, 3'd1);
      key(4'h1);
      key(4'h2);
      key(4'h3);
      tick(499);
      check_now("to_before", StEntry, 1'b0, 1'b0, 3'd1);
      step("to_expire", StIdle, 1'b0, 1'b0, 3'd1);
      code4(4'h1, 4'h2, 4'h3, 4'h4);
      key(4'h5);
      commit("extra_digit", StOpen, 1'b1, 1'b0, 3'd0);
      key_enter = 1'b1;
      step("open_exit2", StIdle, 1'b0, 1'b0, 3'd0);
      key_enter = 1'b0;

      key_change = 1'b1;
      step("chg_idle", StIdle, 1'b0, 1'b0, 3'd0);
      key_change = 1'b0;

      // Code change to 9876
      code4(4'h1, 4'h2, 4'h3, 4'h4);
      commit("open2", StOpen, 1'b1, 1'b0, 3'd0);
      key_change = 1'b1;
      step("newcode", StNewCode, 1'b0, 1'b0, 3'd0);
      key_change = 1'b0;
      code4(4'h9, 4'h8, 4'h7, 4'h6);
      key_enter = 1'b1;
      step("newcode_done", StIdle, 1'b0, 1'b0, 3'd0);
      key_enter = 1'b0;
      code4(4'h1, 4'h2, 4'h3, 4'h4);
      commit("old_fails", StIdle, 1'b0, 1'b0, 3'd1);
      code4(4'h9, 4'h8, 4'h7, 4'h6);
      commit("new_opens", StOpen, 1'b1, 1'b0, 3'd0);

      // Auto relock after the hold time
      ucnt = unlock ? 1 : 0;
      for (int i = 0; i < 1100 && unlock; i++) begin
         tick(1);
         if (unlock) ucnt++;
      end
      checks++;
      assert (ucnt == 1000) else begin
         errors++;
         $error("FAIL open_len: unlock cycles observed %0d required 1000", ucnt);
      end
      check_now("relock", StIdle, 1'b0, 1'b0, 3'd0);

      // Digit presented with enter in the same cycle is dropped
      key(4'h9);
      key(4'h8);
      key(4'h7);
      key_valid = 1'b1;
      key_digit = 4'h6;
      key_enter = 1'b1;
      step("drop_chk", StCheck, 1'b0, 1'b0, 3'd0);
      key_valid = 1'b0;
      key_enter = 1'b0;
      step("drop_fail", StIdle, 1'b0, 1'b0, 3'd1);

      // Asynchronous reset during lockout restores the initial code
      code4(4'h5, 4'h5, 4'h5, 4'h5);
      commit("wrong_b2", StIdle, 1'b0, 1'b0, 3'd2);
      code4(4'h5, 4'h5, 4'h5, 4'h5);
      commit("wrong_b3", StLockout, 1'b0, 1'b1, 3'd3);
      tick(5);
      reset = 1'b0;
      #1 check_now("rst_lock", StIdle, 1'b0, 1'b0, 3'd0);
      tick(1);
      reset = 1'b1;
      tick(1);
      code4(4'h1, 4'h2, 4'h3, 4'h4);
      commit("init_code_back", StOpen, 1'b1, 1'b0, 3'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
